// File: rtl/weight_loader_if.sv
// -----------------------------------------------------------------------------
// weight_loader_if
// Bus bundle between the weight loader, the single-port weight SRAM and the
// row-parallel write port of the weight input FIFO.
//
// Signals:
//   sram_cen   loader -> SRAM   chip enable, active-low
//   sram_wen   loader -> SRAM   write enable, active-low (always 1, read only)
//   sram_addr  loader -> SRAM   read address
//   sram_q     SRAM   -> loader read data, valid the cycle after sram_cen=0
//   fifo_wr    loader -> FIFO   per-row write enables
//   fifo_in    loader -> FIFO   write data
//   fifo_full  FIFO   -> loader full flag
//
// Modports: master = loader side, slave = SRAM/FIFO side.
// -----------------------------------------------------------------------------
interface weight_loader_if #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11
) ();
    logic                sram_cen;
    logic                sram_wen;
    logic [addr_w-1:0]   sram_addr;
    logic [row*bw-1:0]   sram_q;
    logic [row-1:0]      fifo_wr;
    logic [row*bw-1:0]   fifo_in;
    logic                fifo_full;

    modport master (
        output sram_cen, sram_wen, sram_addr, fifo_wr, fifo_in,
        input  sram_q, fifo_full
    );

    modport slave (
        input  sram_cen, sram_wen, sram_addr, fifo_wr, fifo_in,
        output sram_q, fifo_full
    );
endinterface

// File: rtl/weight_loader.sv
// -----------------------------------------------------------------------------
// weight_loader
// Streams a contiguous block of packed weight words from the weight SRAM
// (1-cycle read latency) into the weight FIFO's row-parallel write port.
// A 2-entry skid buffer absorbs FIFO backpressure; a one-cycle done pulse
// marks completion.
//
// Ports:
//   clk        clock, posedge
//   reset      synchronous, active-high
//   start      load request, sampled only in IDLE
//   base_addr  first SRAM address, latched on accepted start
//   num_words  number of words (0..2^addr_w), latched on accepted start
//   row_mask   (optional) per-row write mask, latched on accepted start
//   busy       high while the load is in progress
//   done       one-cycle completion pulse
//   bus        weight_loader_if.master (SRAM read port + FIFO write port)
//
// Optional feature macro: WEIGHT_LOADER_ROW_MASK_EN adds row_mask; when
// undefined every pop writes all rows.
// -----------------------------------------------------------------------------
module weight_loader #(
    parameter int row    = 8,
    parameter int bw     = 4,
    parameter int addr_w = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [addr_w:0]   num_words,
`ifdef WEIGHT_LOADER_ROW_MASK_EN
    input  logic [row-1:0]    row_mask,
`endif
    output logic              busy,
    output logic              done,
    weight_loader_if.master   bus
);
    localparam int W = row * bw;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_READ  = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam logic [addr_w-1:0] ADDR_ONE = {{(addr_w-1){1'b0}}, 1'b1};
    localparam logic [addr_w:0]   CNT_ONE  = {{addr_w{1'b0}}, 1'b1};
    localparam logic [addr_w:0]   CNT_ZERO = {(addr_w+1){1'b0}};

    logic [1:0]        state_r;
    logic [1:0]        state_next_s;
    logic [addr_w-1:0] addr_r;
    logic [addr_w:0]   remain_r;
    logic [1:0]        cnt_r;
    logic              inflight_r;
    logic [W-1:0]      skid0_r;
    logic [W-1:0]      skid1_r;
    logic              pop_s;
    logic              issue_s;
    logic              accept_s;
    logic [1:0]        occ_s;
    logic [row-1:0]    wr_pat_s;

    // Pop, post-cycle occupancy and read-issue decisions
    always_comb begin
        pop_s    = (cnt_r != 2'd0) && !bus.fifo_full;
        // occupancy at end of this cycle: current entries, minus the pop,
        // plus the read data that lands this cycle
        occ_s    = cnt_r - {1'b0, pop_s} + {1'b0, inflight_r};
        // a new read is allowed only if its data will still find a free slot
        issue_s  = (state_r == ST_READ) && (occ_s <= 2'd1);
        accept_s = (state_r == ST_IDLE) && start && (num_words != CNT_ZERO);
    end

    // Next-state logic
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (num_words == CNT_ZERO) begin
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_READ;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_READ: begin
                if (issue_s && (remain_r == CNT_ONE)) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_READ;
                end
            end
            ST_DRAIN: begin
                // finish as soon as the skid will be empty after this cycle
                if (occ_s == 2'd0) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, read address, remaining count and in-flight tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            addr_r     <= {addr_w{1'b0}};
            remain_r   <= CNT_ZERO;
            inflight_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            inflight_r <= issue_s;
            if (accept_s) begin
                addr_r   <= base_addr;
                remain_r <= num_words;
            end else if (issue_s) begin
                // address wraps naturally modulo 2^addr_w
                addr_r   <= addr_r + ADDR_ONE;
                remain_r <= remain_r - CNT_ONE;
            end else begin
                addr_r   <= addr_r;
                remain_r <= remain_r;
            end
        end
    end

    // Skid buffer: capture read data one cycle after issue, shift on pop
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r   <= 2'd0;
            skid0_r <= {W{1'b0}};
            skid1_r <= {W{1'b0}};
        end else begin
            case ({inflight_r, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        skid0_r <= bus.sram_q;
                    end else begin
                        skid1_r <= bus.sram_q;
                    end
                    cnt_r <= cnt_r + 2'd1;
                end
                2'b01: begin
                    skid0_r <= skid1_r;
                    cnt_r   <= cnt_r - 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        skid0_r <= bus.sram_q;
                    end else begin
                        skid0_r <= skid1_r;
                        skid1_r <= bus.sram_q;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

`ifdef WEIGHT_LOADER_ROW_MASK_EN
    logic [row-1:0] mask_r;

    // Row mask latched with the load command
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_r <= {row{1'b0}};
        end else if (accept_s) begin
            mask_r <= row_mask;
        end else begin
            mask_r <= mask_r;
        end
    end

    assign wr_pat_s = mask_r;
`else
    assign wr_pat_s = {row{1'b1}};
`endif

    // Output decode; write enables follow the pop directly so they can never
    // be raised while the FIFO is full
    always_comb begin
        busy          = (state_r == ST_READ) || (state_r == ST_DRAIN);
        done          = (state_r == ST_DONE);
        bus.sram_cen  = ~issue_s;
        bus.sram_wen  = 1'b1;
        bus.sram_addr = addr_r;
        bus.fifo_in   = skid0_r;
        if (pop_s) begin
            bus.fifo_wr = wr_pat_s;
        end else begin
            bus.fifo_wr = {row{1'b0}};
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
`timescale 1ns/1ps
module tb_weight_loader;
    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int AW    = 11;
    localparam int W     = ROW * BW;
    localparam int DEPTH = 2048;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   num_words;
    logic          busy;
    logic          done;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
    logic [ROW-1:0] row_mask;
`endif

    weight_loader_if #(.row(ROW), .bw(BW), .addr_w(AW)) bus ();

    weight_loader #(.row(ROW), .bw(BW), .addr_w(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
`ifdef WEIGHT_LOADER_ROW_MASK_EN
        .row_mask  (row_mask),
`endif
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] mem [DEPTH];

    typedef struct {
        int         base;
        int         num;
        int         stall_lo;
        int         stall_hi;
        logic [7:0] mask;
        int         exp_done;
    } vec_t;

    vec_t tbl [7];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One complete load: cycle 0 is the cycle in which start is presented.
    task automatic run_load(input int base, input int num, input int stall_lo,
                            input int stall_hi, input bit rnd_full,
                            input logic [7:0] mask, input int exp_done);
        logic [W-1:0]  exp_q [$];
        logic [7:0]    exp_wr;
        logic [AW-1:0] rd_addr;
        int            issued;
        int            pops;
        int            cyc;
        int            done_cyc;
        int            idx;
        bit            rd_pend;
        issued   = 0;
        pops     = 0;
        cyc      = 0;
        done_cyc = -1;
        rd_pend  = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < num; i++) begin
            idx = (base + i) % DEPTH;
            exp_q.push_back(mem[idx[AW-1:0]]);
        end
`ifdef WEIGHT_LOADER_ROW_MASK_EN
        exp_wr = mask;
`else
        exp_wr = 8'hFF;
`endif
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = base[AW-1:0];
        num_words = num[AW:0];
`ifdef WEIGHT_LOADER_ROW_MASK_EN
        row_mask  = mask;
`endif
        bus.fifo_full = 1'b0;
        while (done_cyc < 0 && cyc < 300) begin
            @(negedge clk);
            if (bus.sram_cen == 1'b0) begin
                idx = (base + issued) % DEPTH;
                check("read_addr", bus.sram_addr, idx);
                check("read_wen", bus.sram_wen, 1);
                issued++;
                rd_pend = 1'b1;
                rd_addr = bus.sram_addr;
            end else begin
                rd_pend = 1'b0;
            end
            if (bus.fifo_wr != 8'h00) begin
                check("wr_while_full", bus.fifo_full, 0);
                check("wr_pattern", bus.fifo_wr, exp_wr);
                if (pops < num) begin
                    check("word_data", bus.fifo_in, exp_q[pops]);
                end else begin
                    check("extra_word", pops, num);
                end
                pops++;
            end
            check("outstanding_le2", (issued - pops) <= 2, 1);
            if (done) begin
                check("busy_at_done", busy, 0);
                done_cyc = cyc;
            end else begin
                check("busy", busy, (num != 0) && (cyc >= 1));
            end
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            bus.sram_q = rd_pend ? mem[rd_addr] : W'($urandom());
            if (rnd_full) begin
                bus.fifo_full = ($urandom_range(0, 2) == 0);
            end else begin
                bus.fifo_full = (cyc >= stall_lo) && (cyc <= stall_hi);
            end
        end
        check("done_seen", done_cyc >= 0, 1);
        if (exp_done >= 0) begin
            check("done_cycle", done_cyc, exp_done);
        end
        check("words_written", pops, num);
        check("reads_issued", issued, num);
        @(negedge clk);
        check("done_single", done, 0);
        check("idle_busy", busy, 0);
        check("idle_cen", bus.sram_cen, 1);
        check("idle_wr", bus.fifo_wr, 0);
        @(posedge clk); #1;
        bus.fifo_full = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cen", bus.sram_cen, 1);
        check("rst_wen", bus.sram_wen, 1);
        check("rst_addr", bus.sram_addr, 0);
        check("rst_wr", bus.fifo_wr, 0);
        check("rst_in", bus.fifo_in, 0);
    endtask

    initial begin
        int b;
        int n;
        for (int i = 0; i < DEPTH; i++) mem[i] = W'($urandom());

        //        base  num stall_lo stall_hi mask   exp_done
        tbl[0] = '{0,    4,  -1, -2, 8'hFF, 7};
        tbl[1] = '{0,    0,  -1, -2, 8'hFF, 1};
        tbl[2] = '{100,  8,   4,  8, 8'hFF, 16};
        tbl[3] = '{2046, 4,  -1, -2, 8'hFF, 7};
        tbl[4] = '{2040, 16, -1, -2, 8'hFF, 19};
        tbl[5] = '{5,    1,  -1, -2, 8'hFF, 4};
        tbl[6] = '{300,  2,  -1, -2, 8'h0F, 5};

        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
`ifdef WEIGHT_LOADER_ROW_MASK_EN
        row_mask = 8'hFF;
`endif
        bus.fifo_full = 1'b0;
        bus.sram_q = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_reset_values();

        for (int v = 0; v < 7; v++) begin
            run_load(tbl[v].base, tbl[v].num, tbl[v].stall_lo, tbl[v].stall_hi,
                     1'b0, tbl[v].mask, tbl[v].exp_done);
        end

        // Reset in cycle 3 of an 8-word load
        @(posedge clk); #1;
        start = 1'b1;
        base_addr = 11'd40;
        num_words = 12'd8;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            bus.sram_q = W'($urandom());
            reset = (c == 3);
        end
        @(negedge clk);
        check_reset_values();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check("no_done_after_reset", done, 0);
            check("no_read_after_reset", bus.sram_cen, 1);
        end
        run_load(40, 8, -1, -2, 1'b0, 8'hFF, 11);

        // Random loads under random backpressure
        for (int r = 0; r < 20; r++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 24);
            run_load(b, n, -1, -2, 1'b1, 8'($urandom()), (n == 0) ? 1 : -1);
        end
        // Random unstalled loads: done exactly num+3 cycles after start
        for (int r = 0; r < 5; r++) begin
            b = $urandom_range(0, DEPTH - 1);
            n = $urandom_range(1, 30);
            run_load(b, n, -1, -2, 1'b0, 8'hFF, n + 3);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
